// File: rtl/axil_cfg_pkg.sv
// Shared constants for the AXI-Lite configuration register bank.
package axil_cfg_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int REG_VERSION = 0;
    localparam int REG_CTRL    = 1;
    localparam int REG_STATUS  = 14;

    // Word address (byte address bits [31:2]) maps to a register when the
    // upper bits are clear and the word index exists in the bank.
    function automatic logic addr_ok(input logic [29:0] waddr, input int nregs);
        return (waddr[29:4] == 26'd0) && (int'(waddr[3:0]) < nregs);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/axil_cfg_regfile.sv
// AXI-Lite slave bank of 32-bit configuration registers with a self-clearing
// core reset in the control register and a synchronised rx_sync status.
module axil_cfg_regfile
    import axil_cfg_pkg::*;
#(
    parameter int          NUM_REGS         = 16,
    parameter logic [31:0] VERSION          = 32'h0001_0000,
    parameter int          RESET_CLR_CYCLES = 4
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    input  logic [31:0]              s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic                     rx_sync,
    output logic                     core_reset,
    output logic [32*NUM_REGS-1:0]   cfg_regs
);

    localparam int CW = $clog2(RESET_CLR_CYCLES + 1);

    logic              rdy_en;
    logic              aw_held;
    logic              w_held;
    logic [29:0]       awaddr_q;
    logic [31:0]       wdata_q;
    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic              wr_ok;
    logic [3:0]        wr_idx;
    logic              rd_ok;
    logic [3:0]        rd_idx;
    logic [NUM_REGS-1:0] wr_en;
    logic              ctrl_bit;
    logic [CW-1:0]     clr_cnt;
    logic              rx_sync_s;
    logic [31:0]       img [NUM_REGS];

    // Byte-lane bits of the addresses carry no meaning for word accesses.
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    sync_2ff u_rx_sync (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .d     (rx_sync),
        .q     (rx_sync_s)
    );

    // Holds all readies low while in reset and for the edge that releases it.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) rdy_en <= 1'b0;
        else                rdy_en <= 1'b1;
    end

    assign s_axi_awready = rdy_en && !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = rdy_en && !w_held  && !s_axi_bvalid;
    assign s_axi_arready = rdy_en && !s_axi_rvalid;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid  && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_held && w_held && !s_axi_bvalid;

    assign wr_idx = awaddr_q[3:0];
    assign wr_ok  = addr_ok(awaddr_q, NUM_REGS);
    assign rd_idx = s_axi_araddr[5:2];
    assign rd_ok  = addr_ok(s_axi_araddr[31:2], NUM_REGS);

    // Write channel: capture AW and W independently, commit once both are held,
    // then hold the response until the master takes it.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= AXI_RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_axi_awaddr[31:2];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi_wdata;
            end
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    // One-hot write strobe; read-only slots simply ignore theirs.
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NUM_REGS; k++)
            wr_en[k] = commit && wr_ok && (32'(wr_idx) == k);
    end

    // Control bit 0: set with a countdown, cleared on expiry or by writing 0.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ctrl_bit <= 1'b0;
            clr_cnt  <= '0;
        end else if (wr_en[REG_CTRL]) begin
            ctrl_bit <= wdata_q[0];
            clr_cnt  <= wdata_q[0] ? CW'(RESET_CLR_CYCLES) : '0;
        end else if (ctrl_bit) begin
            if (clr_cnt == '0) ctrl_bit <= 1'b0;
            else               clr_cnt  <= clr_cnt - 1'b1;
        end
    end

    assign core_reset = ctrl_bit;

    genvar k;
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_reg
            if (k == REG_VERSION) begin : g_ver
                assign img[k] = VERSION;
            end else if (k == REG_CTRL) begin : g_ctrl
                assign img[k] = {31'b0, ctrl_bit};
            end else if (k == REG_STATUS) begin : g_stat
                assign img[k] = {31'b0, rx_sync_s};
            end else begin : g_rw
                logic [31:0] q;
                // Plain read/write storage word.
                always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                    if (!s_axi_aresetn)  q <= '0;
                    else if (wr_en[k])   q <= wdata_q;
                end
                assign img[k] = q;
            end
            assign cfg_regs[32*k +: 32] = img[k];
        end
    endgenerate

    // Read channel: register data on the AR handshake and hold until taken.
    // A same-edge write is not visible because img is the pre-edge value.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= AXI_RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_ok ? img[rd_idx] : 32'h0;
            s_axi_rresp  <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_cfg_regfile.sv
// Directed bench for axil_cfg_regfile with hand-computed expectations.
module tb_axil_cfg_regfile;

    localparam int NR = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [31:0]     araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic            rx_sync = 1'b0;
    logic            core_reset;
    logic [32*NR-1:0] cfg_regs;

    int errors = 0;
    int checks = 0;
    int cr_cnt = 0;

    axil_cfg_regfile #(.NUM_REGS(NR), .VERSION(32'h0001_0000), .RESET_CLR_CYCLES(4)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .rx_sync       (rx_sync),
        .core_reset    (core_reset),
        .cfg_regs      (cfg_regs)
    );

    always #5 clk = ~clk;

    // Count cycles with core_reset high, sampled mid-cycle.
    always @(negedge clk) if (core_reset) cr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input bit ack,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        chk("wr_bvalid", 32'(bvalid), 32'd1);
        resp = bresp;
        if (ack) begin
            bready = 1'b1; tick(); bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input bit ack,
                            output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        d = rdata; resp = rresp;
        if (ack) begin
            rready = 1'b1; tick(); rready = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]   rs;
        logic [31:0]  rd;
        logic [32*NR-1:0] snap;
        int n;

        // Reset state
        tick(); tick();
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready",  32'(wready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid",  32'(bvalid), 0);
        chk("rst_rvalid",  32'(rvalid), 0);
        chk("rst_core_reset", 32'(core_reset), 0);
        chk("rst_reg2", cfg_regs[95:64], 0);
        rst_n = 1'b1;
        chk("rel_awready_pre", 32'(awready), 0);
        tick();
        chk("rel_awready", 32'(awready), 1);
        chk("rel_wready",  32'(wready), 1);
        chk("rel_arready", 32'(arready), 1);

        // AW+W same cycle to 0x08
        awaddr = 32'h08; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_bvalid_n", 32'(bvalid), 0);
        tick();
        chk("t1_bvalid", 32'(bvalid), 1);
        chk("t1_bresp", 32'(bresp), 0);
        chk("t1_cfg2", cfg_regs[95:64], 32'h1);
        bready = 1'b1; tick(); bready = 1'b0;
        chk("t1_bvalid_clr", 32'(bvalid), 0);
        axi_read(32'h08, 1, rd, rs);
        chk("t1_rdata", rd, 32'h1);
        chk("t1_rresp", 32'(rs), 0);

        // W three cycles ahead of AW
        awaddr = 32'h24; wdata = 32'h1F; wvalid = 1'b1;
        tick();
        wdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            chk("t2_wready_held", 32'(wready), 0);
            tick();
        end
        chk("t2_awready", 32'(awready), 1);
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("t2_bvalid_n", 32'(bvalid), 0);
        chk("t2_wready_aw", 32'(wready), 0);
        tick();
        chk("t2_bvalid", 32'(bvalid), 1);
        chk("t2_wready_b", 32'(wready), 0);
        wvalid = 1'b0;
        bready = 1'b1; tick(); bready = 1'b0;
        chk("t2_wready_free", 32'(wready), 1);
        chk("t2_cfg9", cfg_regs[32*9 +: 32], 32'h1F);
        axi_read(32'h24, 1, rd, rs);
        chk("t2_rdata", rd, 32'h1F);

        // Self-clearing core reset
        cr_cnt = 0;
        axi_write(32'h04, 32'h1, 1, rs);
        chk("t3_bresp", 32'(rs), 0);
        axi_read(32'h04, 1, rd, rs);
        chk("t3_rd_first", rd, 32'h1);
        n = 0;
        while (rd != 0 && n < 20) begin
            axi_read(32'h04, 1, rd, rs);
            n++;
        end
        chk("t3_rd_cleared", rd, 32'h0);
        chk("t3_high_cycles", 32'(cr_cnt), 32'd5);
        axi_write(32'h04, 32'hFFFF_FFFF, 1, rs);
        chk("t3_ctrl_bits", cfg_regs[63:32], 32'h1);
        axi_write(32'h04, 32'h0, 1, rs);
        chk("t3_clear_now", 32'(core_reset), 0);

        // rx_sync status, version register
        rx_sync = 1'b1;
        chk("t4_sync_e0", 32'(cfg_regs[32*14]), 0);
        tick();
        chk("t4_sync_e1", 32'(cfg_regs[32*14]), 0);
        tick();
        chk("t4_sync_e2", 32'(cfg_regs[32*14]), 1);
        axi_read(32'h38, 1, rd, rs);
        chk("t4_rd_status", rd, 32'h1);
        axi_read(32'h00, 1, rd, rs);
        chk("t4_rd_version", rd, 32'h0001_0000);
        axi_write(32'h00, 32'hDEAD_BEEF, 1, rs);
        chk("t4_ro_bresp", 32'(rs), 0);
        axi_read(32'h00, 1, rd, rs);
        chk("t4_rd_version2", rd, 32'h0001_0000);
        axi_write(32'h38, 32'h0, 1, rs);
        chk("t4_status_ro", cfg_regs[32*14 +: 32], 32'h1);

        // Out of range
        snap = cfg_regs;
        axi_write(32'h40, 32'h1234_5678, 1, rs);
        chk("t5_wr_slverr", 32'(rs), 32'h2);
        chk("t5_no_change", 32'(cfg_regs == snap), 1);
        axi_read(32'h7C, 1, rd, rs);
        chk("t5_rd_data", rd, 0);
        chk("t5_rd_slverr", 32'(rs), 32'h2);
        axi_read(32'h1000_0008, 1, rd, rs);
        chk("t5_rd_hi_slverr", 32'(rs), 32'h2);

        // Backpressure hold then reset mid-hold
        axi_write(32'h0C, 32'hA5, 0, rs);
        axi_read(32'h08, 0, rd, rs);
        for (int i = 0; i < 5; i++) begin
            chk("t6_bvalid", 32'(bvalid), 1);
            chk("t6_bresp", 32'(bresp), 0);
            chk("t6_rvalid", 32'(rvalid), 1);
            chk("t6_rdata", rdata, 32'h1);
            chk("t6_awready", 32'(awready), 0);
            chk("t6_wready", 32'(wready), 0);
            chk("t6_arready", 32'(arready), 0);
            tick();
        end
        chk("t6_cfg3", cfg_regs[32*3 +: 32], 32'hA5);
        rst_n = 1'b0;
        #1;
        chk("t6r_bvalid", 32'(bvalid), 0);
        chk("t6r_rvalid", 32'(rvalid), 0);
        chk("t6r_rdata", rdata, 0);
        chk("t6r_awready", 32'(awready), 0);
        chk("t6r_arready", 32'(arready), 0);
        chk("t6r_cfg3", cfg_regs[32*3 +: 32], 0);
        chk("t6r_cfg14", cfg_regs[32*14 +: 32], 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t6p_bvalid", 32'(bvalid), 0);
        chk("t6p_rvalid", 32'(rvalid), 0);
        chk("t6p_awready", 32'(awready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_cfg_regfile.md
# axil_cfg_regfile

AXI-Lite slave register bank for the link-control core, sitting directly downstream of the AXI-Lite configuration master (auto-config sequencer plus its write/read channel engines). It accepts single-beat, full-word writes and reads and holds 16 × 32-bit configuration registers. It generates a self-clearing core reset pulse from register 1 and exposes a synchronised receive-sync status in register 14, the register the master polls after reset.

## Interface
Parameters:
- NUM_REGS, 16, number of 32-bit registers; word index = s_axi_awaddr/araddr[5:2]
- VERSION, 32'h0001_0000, read-only value of register 0
- RESET_CLR_CYCLES, 4, cycles core_reset stays high after a write of 1 to reg 1 bit 0 (≥1)

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset, asynchronous assert, active-low
- s_axi_awaddr  in  32  write byte address
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data, full word, no strobes
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  32  read byte address
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, encoded as bresp
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- rx_sync  in  1  asynchronous receive-sync status from the link
- core_reset  out  1  link-core reset, equal to reg 1 bit 0
- cfg_regs  out  32*NUM_REGS  flat register image; reg k is at [32k+31:32k]

## Operation
- Register map:
  - reg 0 is RO VERSION.
  - reg 1 bit 0 is RW and self-clearing; other bits of reg 1 read 0.
  - reg 14 is RO {31'b0, rx_sync_s}.
  - All other regs are RW.
- Address decode:
  - In range means addr[31:6] == 0; addr[1:0] is ignored.
  - Out of range: writes are dropped with bresp SLVERR; reads return rdata 0 with rresp SLVERR.
  - Writes to RO regs are dropped with bresp OKAY.
- Write path: AW and W are accepted independently and may arrive in either order, any gap apart.
  - Flags aw_held and w_held hold each accepted beat.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Commit cycle: aw_held && w_held && !bvalid. Write the register, set bvalid and bresp, clear both flags.
  - bvalid holds until bready. No new AW/W is accepted while bvalid is high.
- Read path: arready = !rvalid.
  - On an AR handshake, rdata/rresp are registered and rvalid is set the next cycle.
  - rvalid and rdata hold until rready.
  - Read and write paths are fully independent and may complete in the same cycle.
- Self-clear:
  - A committed write with wdata[0]=1 to reg 1 sets bit 0 and loads the counter with RESET_CLR_CYCLES.
  - The counter decrements each cycle; when it reaches 0, bit 0 clears.
  - A rewrite of 1 during the countdown reloads the counter. A write of 0 clears bit 0 immediately.
- rx_sync passes through a 2-flop synchroniser to give rx_sync_s.

## Timing
- Reset values (async on s_axi_aresetn low):
  - All ready/valid/flag outputs 0; bresp/rresp 0; rdata 0; core_reset 0.
  - All RW regs 0; counter 0; synchroniser flops 0.
  - Readies rise in the first cycle after reset release.
- Reset mid-transaction abandons it; no response is issued afterwards.
- Write latency: with AW and W handshaking at edge N, the commit is at edge N+1 and bvalid is high after N+1. cfg_regs and core_reset update at the same edge.
- Read latency: AR handshake at edge N, rvalid high after edge N.
- A read of a register committed at the same edge returns the old value.
- core_reset is high for exactly RESET_CLR_CYCLES+1 cycles (load cycle plus countdown).
- rx_sync to readable rx_sync_s latency: 2 edges.

## Structure
- Shared package axil_cfg_pkg holds:
  - AXI_RESP_OKAY and AXI_RESP_SLVERR
  - register indices REG_VERSION=0, REG_CTRL=1, REG_STATUS=14
- One sub-module: sync_2ff (generic 2-flop synchroniser, async active-low reset) for rx_sync.
- Write and read channels live in the top as separate always blocks.

## Test plan
- AW+W in the same cycle to 0x08 with data 0x1 → bvalid after 2 edges, bresp 00; then read 0x08 → rdata 0x1, rresp 00; cfg_regs[95:64]=0x1.
- W presented 3 cycles before AW (addr 0x24, data 0x1F) → exactly one write; wready low after W accepted until B completes; readback 0x1F.
- Write 0x1 to 0x04 → core_reset high 5 cycles; poll 0x04 repeatedly → reads 1 then 0 after countdown.
- rx_sync driven 1 → read 0x38 returns 1 starting 2 edges later; read 0x00 → 0x0001_0000; write 0x00 → bresp OKAY, value unchanged.
- Out of range: write 0x40 → bresp 10, no cfg_regs change; read 0x7C → rdata 0, rresp 10.
- bready/rready held low 5 cycles → bvalid/rvalid and data stable, awready/wready/arready low. Assert reset mid-hold → all outputs return to reset values immediately.
